uart_rx_8n1: RTL and testbench



---
 rtl/uart_rx_8n1_pkg.sv | 16 +
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx_8n1.sv | 126 ++++++++++++
 tb/tb_uart_rx_8n1.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_8n1_pkg.sv
// Shared UART definitions: state encodings, frame width and default bit timing.
// Kept in a package so the transmitter can import the same constants.
package uart_rx_8n1_pkg;

  localparam int unsigned UART_DATA_BITS       = 8;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// RST_VAL sets the level both flops take on reset (idle line level).
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: oversampled mid-bit sampling, glitch-rejecting start,
// framing-error detection and break hold-off until the line returns high.
module uart_rx_8n1
  import uart_rx_8n1_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rxbyte,
  output logic                      rxdone,
  output logic                      rxerror,
  output logic                      busy
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(UART_DATA_BITS - 1);

  logic rx_s;

  uart_state_e               state_q, state_d;
  logic [CNT_W-1:0]          clk_cnt_q, clk_cnt_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] rxbyte_d;
  logic                      rxdone_d, rxerror_d, busy_d;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rxbyte    <= '0;
      rxdone    <= 1'b0;
      rxerror   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rxbyte    <= rxbyte_d;
      rxdone    <= rxdone_d;
      rxerror   <= rxerror_d;
      busy      <= busy_d;
    end
  end

  // Counters run from the cycle after each decision point, so a count of
  // HALF_LAST / CNT_LAST lands exactly on the mid-bit sample cycle.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rxbyte_d  = rxbyte;
    rxdone_d  = 1'b0;
    rxerror_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d   = ST_START;
          clk_cnt_d = '0;
        end
      end
      ST_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'(1);
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            rxbyte_d = shift_q;
            rxdone_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            rxerror_d = 1'b1;
            state_d   = ST_BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1; a behavioural 8N1 transmitter drives rx and
// a negedge monitor logs every strobe with its cycle number.
module tb_uart_rx_8n1;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rxbyte;
  logic       rxdone, rxerror, busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int         done_cyc[$];
  logic [7:0] done_byte[$];
  int         err_n   = 0;
  int         err_cyc = -1;
  int         both_n  = 0;

  uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .rxbyte  (rxbyte),
    .rxdone  (rxdone),
    .rxerror (rxerror),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (rxdone) begin
        done_cyc.push_back(cyc);
        done_byte.push_back(rxbyte);
      end
      if (rxerror) begin
        err_n++;
        err_cyc = cyc;
      end
      if (rxdone && rxerror) both_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    done_cyc.delete();
    done_byte.delete();
    err_n   = 0;
    err_cyc = -1;
  endtask

  function automatic int dc(input int i);
    return (i < done_cyc.size()) ? done_cyc[i] : -1;
  endfunction

  function automatic logic [7:0] db(input int i);
    return (i < done_byte.size()) ? done_byte[i] : 8'hxx;
  endfunction

  // Called on a negedge; returns on the negedge ending the stop bit, rx left at stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop_val);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_val;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int s;
    int early;
    logic [7:0] exp_q[$];

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_rxbyte", 32'(rxbyte), 32'h00);
    chk("rst_rxdone", 32'(rxdone), 32'h0);
    chk("rst_rxerror", 32'(rxerror), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    idle(10);

    // Single frame '%': rx falls at s, rx_s at s+2 (T0), rxdone at T0+153
    clear_log();
    s = cyc;
    send_frame(8'h25, 1'b1);
    idle(20);
    chk("pct_count", 32'(done_cyc.size()), 32'd1);
    chk("pct_byte", 32'(db(0)), 32'h25);
    chk("pct_time", 32'(dc(0)), 32'(s + 155));
    chk("pct_err", 32'(err_n), 32'd0);
    chk("pct_rxbyte", 32'(rxbyte), 32'h25);

    // Framing error then break held for 40 bit times
    clear_log();
    s = cyc;
    send_frame(8'h33, 1'b0);
    repeat (20 * CPB) @(negedge clk);
    chk("brk_busy_mid", 32'(busy), 32'h1);
    repeat (20 * CPB) @(negedge clk);
    chk("brk_err_count", 32'(err_n), 32'd1);
    chk("brk_err_time", 32'(err_cyc), 32'(s + 155));
    chk("brk_no_done", 32'(done_cyc.size()), 32'd0);
    chk("brk_rxbyte", 32'(rxbyte), 32'h25);
    chk("brk_busy_end", 32'(busy), 32'h1);
    idle(20);
    chk("brk_busy_rel", 32'(busy), 32'h0);
    clear_log();
    send_frame(8'hA5, 1'b1);
    idle(20);
    chk("brk_next_count", 32'(done_cyc.size()), 32'd1);
    chk("brk_next_byte", 32'(db(0)), 32'hA5);
    chk("brk_next_err", 32'(err_n), 32'd0);

    // Back-to-back frames, no idle gap
    clear_log();
    send_frame(8'h41, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    chk("b2b_count", 32'(done_cyc.size()), 32'd3);
    chk("b2b_byte0", 32'(db(0)), 32'h41);
    chk("b2b_byte1", 32'(db(1)), 32'h00);
    chk("b2b_byte2", 32'(db(2)), 32'hFF);
    chk("b2b_gap01", 32'(dc(1) - dc(0)), 32'd160);
    chk("b2b_gap12", 32'(dc(2) - dc(1)), 32'd160);
    chk("b2b_err", 32'(err_n), 32'd0);

    // Start glitch of 4 clocks: T0 = s+2, busy up at T0+1, down by T0+9
    clear_log();
    s = cyc;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    while (cyc < s + 5) @(negedge clk);
    chk("gl_busy_up", 32'(busy), 32'h1);
    while (cyc < s + 11) @(negedge clk);
    chk("gl_busy_down", 32'(busy), 32'h0);
    idle(40);
    chk("gl_no_done", 32'(done_cyc.size()), 32'd0);
    chk("gl_no_err", 32'(err_n), 32'd0);
    send_frame(8'h5A, 1'b1);
    idle(20);
    chk("gl_next_count", 32'(done_cyc.size()), 32'd1);
    chk("gl_next_byte", 32'(db(0)), 32'h5A);

    // Reset pulse during data bit 4 of 8'hC3
    clear_log();
    s = cyc;
    fork
      send_frame(8'hC3, 1'b1);
      begin
        repeat (88) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_rxbyte", 32'(rxbyte), 32'h00);
        chk("mid_rst_rxdone", 32'(rxdone), 32'h0);
        chk("mid_rst_rxerror", 32'(rxerror), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
      end
    join
    idle(200);
    early = 0;
    foreach (done_cyc[i]) if (done_cyc[i] <= s + 160) early++;
    if (err_cyc >= 0 && err_cyc <= s + 160) early++;
    chk("mid_rst_no_strobe", 32'(early), 32'd0);
    clear_log();
    send_frame(8'h7E, 1'b1);
    idle(20);
    chk("mid_rst_next_count", 32'(done_cyc.size()), 32'd1);
    chk("mid_rst_next_byte", 32'(db(0)), 32'h7E);
    chk("mid_rst_next_err", 32'(err_n), 32'd0);

    // Loopback of 256 random bytes, back-to-back
    clear_log();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(255));
      exp_q.push_back(b);
      send_frame(b, 1'b1);
    end
    idle(20);
    chk("loop_count", 32'(done_cyc.size()), 32'd256);
    chk("loop_err", 32'(err_n), 32'd0);
    for (int i = 0; i < 256; i++) chk($sformatf("loop_byte%0d", i), 32'(db(i)), 32'(exp_q[i]));

    chk("never_both", 32'(both_n), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
